// File: rtl/bf_console_pkg.sv
// Shared types and constants for the brainfuck console bridge.
package bf_console_pkg;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push at full is accepted when a pop happens the same cycle.
module bf_sync_fifo
    import bf_console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bf_console.sv
// Console bridge: buffers processor stdout into a UART transmitter and receiver bytes into stdin,
// stalling the processor only when a FIFO cannot serve it.
module bf_console
    import bf_console_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int LF_TO_CRLF = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] stdout,
    input  logic       stdout_en,
    input  logic       stdin_req,
    output logic [7:0] stdin,
    output logic       stdin_en,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cpu_en,
    output logic       uart_tx_pin,
    output logic       tx_busy,
    output logic [1:0] overflow
);

    localparam int DIV_W = (CLK_DIV > 2) ? clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    ser_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             cr_sent_q, cr_sent_d;
    logic             pin_q, pin_d;
    logic             run_q;
    logic [7:0]       stdin_q, stdin_d;
    logic             stdin_en_q, stdin_en_d;
    logic [1:0]       ovf_q, ovf_d;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic       div_done;

    bf_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (stdout),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    bf_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // run_q keeps the core halted for the first cycle after reset is released.
    assign cpu_en  = run_q && !tx_full && !(stdin_req && rx_empty && !stdin_en_q);
    assign tx_push = stdout_en && cpu_en && !tx_full;
    assign rx_pop  = stdin_req && !rx_empty && !stdin_en_q;

    assign stdin_d    = rx_pop ? rx_dout : stdin_q;
    assign stdin_en_d = rx_pop;
    assign ovf_d      = ovf_q | {rx_valid && rx_full && !rx_pop, stdout_en && tx_full};

    assign div_done = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cr_sent_d = cr_sent_q;
        tx_pop    = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (!tx_empty) begin
                    state_d   = SER_START;
                    div_cnt_d = '0;
                    // A pending LF first emits CR without popping; cr_sent_q stops a repeat.
                    if ((LF_TO_CRLF != 0) && (tx_dout == ASCII_LF) && !cr_sent_q) begin
                        shift_d   = ASCII_CR;
                        cr_sent_d = 1'b1;
                    end else begin
                        shift_d   = tx_dout;
                        tx_pop    = 1'b1;
                        cr_sent_d = 1'b0;
                    end
                end
            end
            SER_START: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = SER_DATA;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            SER_DATA: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = SER_STOP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            SER_STOP: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    state_d   = SER_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // The pin is registered from next state so the line never glitches.
        unique case (state_d)
            SER_START: pin_d = 1'b0;
            SER_DATA:  pin_d = shift_d[0];
            default:   pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= SER_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            cr_sent_q  <= 1'b0;
            pin_q      <= 1'b1;
            run_q      <= 1'b0;
            stdin_q    <= '0;
            stdin_en_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cr_sent_q  <= cr_sent_d;
            pin_q      <= pin_d;
            run_q      <= 1'b1;
            stdin_q    <= stdin_d;
            stdin_en_q <= stdin_en_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign uart_tx_pin = pin_q;
    assign tx_busy     = (state_q != SER_IDLE) || !tx_empty;
    assign stdin       = stdin_q;
    assign stdin_en    = stdin_en_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_bf_console.sv
// Scoreboard bench for bf_console: serial frames and stdin bytes are compared against queued expectations.
module tb_bf_console;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] stdout, stdout1;
    logic       stdout_en, stdout_en1;
    logic       stdin_req;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic [7:0] stdin, stdin1;
    logic       stdin_en, stdin_en1;
    logic       cpu_en, cpu_en1;
    logic       pin0, pin1;
    logic       tx_busy, tx_busy1;
    logic [1:0] overflow, overflow1;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq0[$];
    logic [7:0] txq1[$];
    logic [7:0] rxq[$];
    logic       dec_busy0 = 1'b0;
    logic       dec_busy1 = 1'b0;
    logic       abort0 = 1'b0;

    always #5 clk = ~clk;

    bf_console #(.CLK_DIV(DIV), .TX_DEPTH(4), .RX_DEPTH(2), .LF_TO_CRLF(1)) u_dut (
        .clk(clk), .rstn(rstn), .stdout(stdout), .stdout_en(stdout_en),
        .stdin_req(stdin_req), .stdin(stdin), .stdin_en(stdin_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .cpu_en(cpu_en),
        .uart_tx_pin(pin0), .tx_busy(tx_busy), .overflow(overflow)
    );

    bf_console #(.CLK_DIV(DIV), .TX_DEPTH(4), .RX_DEPTH(2), .LF_TO_CRLF(0)) u_dut_lf (
        .clk(clk), .rstn(rstn), .stdout(stdout1), .stdout_en(stdout_en1),
        .stdin_req(1'b0), .stdin(stdin1), .stdin_en(stdin_en1),
        .rx_data(8'h00), .rx_valid(1'b0), .cpu_en(cpu_en1),
        .uart_tx_pin(pin1), .tx_busy(tx_busy1), .overflow(overflow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pin_of(input int ch);
        return (ch == 0) ? pin0 : pin1;
    endfunction

    // Serial receiver model: captures 10 bit slots of DIV samples each and checks every sample.
    task automatic decode(input int ch);
        logic [10*DIV-1:0] s;
        logic [7:0]        b;
        logic              ok;
        logic [7:0]        e;
        forever begin
            @(negedge clk);
            if (pin_of(ch) == 1'b0) begin
                if (ch == 0) dec_busy0 = 1'b1; else dec_busy1 = 1'b1;
                s[0] = 1'b0;
                for (int k = 1; k < 10*DIV; k++) begin
                    @(negedge clk);
                    s[k] = pin_of(ch);
                end
                ok = (s[0] == 1'b0) && (s[9*DIV] == 1'b1);
                for (int slot = 0; slot < 10; slot++)
                    for (int j = 1; j < DIV; j++)
                        if (s[slot*DIV+j] != s[slot*DIV]) ok = 1'b0;
                for (int i = 0; i < 8; i++) b[i] = s[(i+1)*DIV];
                if (!(ch == 0 && abort0)) begin
                    if (ch == 0) begin
                        check("frame_shape0", ok, 1);
                        if (txq0.size() == 0) check("tx0_unexpected", b, 32'h100);
                        else begin e = txq0.pop_front(); check("tx0_byte", b, e); end
                    end else begin
                        check("frame_shape1", ok, 1);
                        if (txq1.size() == 0) check("tx1_unexpected", b, 32'h100);
                        else begin e = txq1.pop_front(); check("tx1_byte", b, e); end
                    end
                end
                if (ch == 0) dec_busy0 = 1'b0; else dec_busy1 = 1'b0;
            end
        end
    endtask

    initial decode(0);
    initial decode(1);

    initial begin : stdin_mon
        logic       prev_en;
        logic [7:0] e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (stdin_en && prev_en) check("stdin_en_gap", 1, 0);
            if (stdin_en) begin
                if (rxq.size() == 0) check("stdin_unexpected", stdin, 32'h100);
                else begin e = rxq.pop_front(); check("stdin_byte", stdin, e); end
            end
            prev_en = stdin_en;
        end
    end

    task automatic wait_tx_idle(input int budget);
        int n;
        n = 0;
        while ((tx_busy || tx_busy1 || dec_busy0 || dec_busy1 ||
                txq0.size() != 0 || txq1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("tx_idle_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int lows;
        rstn = 1'b0; stdout = 8'h00; stdout_en = 1'b0; stdout1 = 8'h00; stdout_en1 = 1'b0;
        stdin_req = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pin", pin0, 1);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_stdin_en", stdin_en, 0);
        check("rst_stdin", stdin, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_overflow", overflow, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("cpu_en_rise", cpu_en, 1);

        // Single frame
        stdout = 8'h41; stdout_en = 1'b1; txq0.push_back(8'h41);
        @(negedge clk);
        stdout_en = 1'b0;
        wait_tx_idle(200);
        check("tx_busy_after_frame", tx_busy, 0);

        // Burst until the TX FIFO stalls the core
        n = 0;
        while (cpu_en && n < 8) begin
            stdout = 8'h60 + 8'(n); stdout_en = 1'b1; txq0.push_back(8'h60 + 8'(n));
            n++;
            @(negedge clk);
        end
        stdout_en = 1'b0;
        check("burst_stall", cpu_en, 0);
        check("burst_blocked", (n < 8), 1);
        check("burst_no_ovf", overflow, 0);
        stdout = 8'hEE; stdout_en = 1'b1;
        @(negedge clk);
        stdout_en = 1'b0;
        check("tx_ovf", overflow[0], 1);
        wait_tx_idle(2000);

        // LF expansion on one instance, pass-through on the other
        stdout = 8'h0A; stdout_en = 1'b1; stdout1 = 8'h0A; stdout_en1 = 1'b1;
        txq0.push_back(8'h0D); txq0.push_back(8'h0A); txq1.push_back(8'h0A);
        @(negedge clk);
        stdout = 8'h42; stdout1 = 8'h42;
        txq0.push_back(8'h42); txq1.push_back(8'h42);
        @(negedge clk);
        stdout_en = 1'b0; stdout_en1 = 1'b0;
        wait_tx_idle(1000);

        // stdin stall and single byte delivery
        stdin_req = 1'b1;
        @(negedge clk);
        check("stdin_stall", cpu_en, 0);
        rx_data = 8'h37; rx_valid = 1'b1; rxq.push_back(8'h37);
        @(negedge clk);
        rx_valid = 1'b0;
        check("stdin_resume", cpu_en, 1);
        check("stdin_lat0", stdin_en, 0);
        @(negedge clk);
        check("stdin_lat1", stdin_en, 1);
        stdin_req = 1'b0;
        @(negedge clk);
        check("stdin_pulse", stdin_en, 0);
        check("stdin_cpu_en", cpu_en, 1);

        // RX overflow, then drain the two retained bytes
        rx_valid = 1'b1; rx_data = 8'h11; rxq.push_back(8'h11);
        @(negedge clk);
        rx_data = 8'h22; rxq.push_back(8'h22);
        @(negedge clk);
        rx_data = 8'h33;
        @(negedge clk);
        rx_valid = 1'b0;
        check("rx_ovf", overflow[1], 1);
        stdin_req = 1'b1;
        n = 0;
        while (rxq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        stdin_req = 1'b0;
        check("rx_reads", rxq.size(), 0);

        // Reset in the middle of a frame
        abort0 = 1'b1;
        stdout = 8'h55; stdout_en = 1'b1;
        @(negedge clk);
        stdout_en = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midrst_pin", pin0, 1);
        check("midrst_tx_busy", tx_busy, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_cpu_en", cpu_en, 0);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!pin0) lows++;
        end
        check("midrst_no_resume", lows, 0);
        check("midrst_cpu_en_back", cpu_en, 1);
        abort0 = 1'b0;

        check("txq0_drained", txq0.size(), 0);
        check("txq1_drained", txq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
